// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay_line slice: scheduler latency, scheduler FSM
// encoding and the burst-length derivation used to size BUSY_CYCLES.
package delay_line_pkg;

  // Cycles from a sampled request to the pulse_gen trigger; the delay_line top
  // subtracts this from its DELAY constant.
  localparam int unsigned SCHED_LATENCY = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFire  = 2'd1,
    StBusy  = 2'd2,
    StGuard = 2'd3
  } sched_state_e;

  // One burst is `pulses` full modulation periods of two half-periods each.
  function automatic int unsigned busy_cycles_from_mod(input int unsigned clks_per_half,
                                                       input int unsigned pulses);
    return 2 * clks_per_half * pulses;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after `start`,
// wrapping modulo N_CH.
module rr_pick #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [N_CH-1:0]  gnt,
  output logic             valid
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = SEL_W'((32'(start) + k) % N_CH);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/trigger_scheduler.sv
// Arbitrates N_CH delay-channel triggers onto one shared pulse_gen: latches
// requests, grants round-robin and holds off new triggers for burst + guard.
module trigger_scheduler
  import delay_line_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned BUSY_CYCLES  = 72,
  parameter int unsigned GUARD_CYCLES = 8,
  parameter int unsigned DROP_WIDTH   = 16,
  localparam int unsigned SelW        = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [N_CH-1:0]       req,
  output logic                  trigger,
  output logic [SelW-1:0]       sel,
  output logic                  busy,
  output logic [N_CH-1:0]       pending,
  output logic [DROP_WIDTH-1:0] drop_count,
  input  logic                  drop_clear
);

  localparam int unsigned MaxCnt    = (BUSY_CYCLES > GUARD_CYCLES) ? BUSY_CYCLES : GUARD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCnt + 1);
  // Counters hold remaining cycles minus one; FIRE already covers one busy cycle.
  localparam int unsigned BusyLoad  = (BUSY_CYCLES > 1) ? BUSY_CYCLES - 2 : 0;
  localparam int unsigned GuardLoad = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

  sched_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [SelW-1:0]       ptr_q, ptr_d;
  logic [N_CH-1:0]       pending_q, pending_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  logic [N_CH-1:0]       cand, pick, gnt, drop;
  logic                  pick_valid, grant;
  logic [DROP_WIDTH:0]   ndrop, sum;

  assign cand  = pending_q | req;
  assign grant = (state_q == StIdle) && pick_valid;
  assign gnt   = grant ? pick : '0;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SelW)
  ) u_rr_pick (
    .req   (cand),
    .start (ptr_q),
    .gnt   (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StFire;
      end
      StFire: begin
        if (BUSY_CYCLES > 1) begin
          state_d = StBusy;
          cnt_d   = CntW'(BusyLoad);
        end else if (GUARD_CYCLES > 0) begin
          state_d = StGuard;
          cnt_d   = CntW'(GuardLoad);
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (GUARD_CYCLES > 0) begin
          state_d = StGuard;
          cnt_d   = CntW'(GuardLoad);
        end else begin
          state_d = StIdle;
        end
      end
      StGuard: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        else             state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_d = SelW'(i);
        ptr_d = (i == N_CH - 1) ? '0 : SelW'(i + 1);
      end
    end

    // A granted channel stays pending only if it re-requests in its grant cycle.
    drop = req & pending_q & ~gnt;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pending_d[i] = gnt[i] ? (pending_q[i] & req[i]) : (pending_q[i] | req[i]);
    end

    ndrop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ndrop = ndrop + (DROP_WIDTH + 1)'(drop[i]);
    end
    sum = {1'b0, drop_q} + ndrop;

    if (drop_clear)          drop_d = ndrop[DROP_WIDTH-1:0];
    else if (sum[DROP_WIDTH]) drop_d = '1;
    else                     drop_d = sum[DROP_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sel_q     <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    trigger = (state_q == StFire);
    busy    = (state_q != StIdle);
  end

  assign sel        = sel_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: directed scenarios plus random traffic checked
// against a cycle-count reference model of the arbitration rules.
module tb_trigger_scheduler;

  localparam int BUSY    = 72;
  localparam int GUARD   = 8;
  localparam int SPACING = BUSY + GUARD + 1;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  req;
  logic        drop_clear;
  logic        trigger;
  logic [1:0]  sel;
  logic        busy;
  logic [3:0]  pending;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a channel occupies the generator for BUSY+GUARD cycles
  // after its grant; the idle cycle that follows is when the next grant is taken.
  logic        exp_trigger, exp_busy;
  logic [1:0]  exp_sel;
  logic [3:0]  exp_pending;
  logic [15:0] exp_drop;
  int          m_ptr, m_left, m_drops, m_raw_drops;

  always #5 clk = ~clk;

  trigger_scheduler #(
    .N_CH         (4),
    .BUSY_CYCLES  (BUSY),
    .GUARD_CYCLES (GUARD),
    .DROP_WIDTH   (16)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req        (req),
    .trigger    (trigger),
    .sel        (sel),
    .busy       (busy),
    .pending    (pending),
    .drop_count (drop_count),
    .drop_clear (drop_clear)
  );

  task automatic model_reset();
    exp_trigger = 1'b0; exp_busy = 1'b0; exp_sel = 2'd0;
    exp_pending = 4'd0; exp_drop = 16'd0;
    m_ptr = 0; m_left = 0; m_drops = 0; m_raw_drops = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic c);
    logic [3:0] g;
    logic [3:0] cand;
    logic [3:0] np;
    int nd;
    g = 4'd0; nd = 0; exp_trigger = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else begin
      cand = exp_pending | r;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (g == 4'd0 && cand[idx]) begin
          g[idx] = 1'b1;
          exp_sel = 2'(idx);
          m_ptr = (idx + 1) % 4;
          m_left = BUSY + GUARD;
          exp_trigger = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (r[i] && exp_pending[i] && !g[i]) nd++;
      if (g[i]) np[i] = exp_pending[i] && r[i];
      else      np[i] = exp_pending[i] || r[i];
    end
    exp_pending = np;
    exp_busy = (m_left > 0);
    m_raw_drops += nd;
    if (c) m_drops = nd;
    else   m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
    exp_drop = 16'(m_drops);
  endtask

  task automatic step(input logic [3:0] r, input logic c);
    req = r;
    drop_clear = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    req = 4'd0;
    drop_clear = 1'b0;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    req = 4'd0;
    drop_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    req = 4'd0;
    drop_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %b want 0", trigger); end
    checks++;
    if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    @(negedge clk);
    n_reset = 1'b1;
    step(4'd0, 1'b0);
    checks++;
    if (busy !== 1'b0 || trigger !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b trig=%b want 0 0", busy, trigger);
    end
  endtask

  task automatic test_single();
    int nbusy;
    apply_reset();
    step(4'b0001, 1'b0);
    checks++;
    if (trigger !== 1'b1 || sel !== 2'd0 || busy !== 1'b1 || pending !== 4'd0) begin
      errors++;
      $display("FAIL single_first got trig=%b sel=%0d busy=%b pend=%b want 1 0 1 0000",
               trigger, sel, busy, pending);
    end
    nbusy = 1;
    for (int c = 1; c < 100; c++) begin
      step(4'd0, 1'b0);
      if (busy === 1'b1) nbusy++;
      checks++;
      if (trigger !== exp_trigger || busy !== exp_busy) begin
        errors++;
        $display("FAIL single_cyc %0d got trig=%b busy=%b want %b %b",
                 c, trigger, busy, exp_trigger, exp_busy);
      end
    end
    checks++;
    if (nbusy != BUSY + GUARD) begin
      errors++; $display("FAIL single_busy_len got %0d want %0d", nbusy, BUSY + GUARD);
    end
  endtask

  task automatic test_burst();
    int ntrig;
    int t_at[4];
    logic [1:0] s_at[4];
    apply_reset();
    ntrig = 0;
    for (int k = 0; k < 4; k++) begin t_at[k] = -1; s_at[k] = 2'd0; end
    for (int c = 0; c < 4 * SPACING; c++) begin
      step((c == 0) ? 4'b1111 : 4'b0000, 1'b0);
      checks++;
      if (trigger !== exp_trigger || busy !== exp_busy || sel !== exp_sel ||
          pending !== exp_pending || drop_count !== exp_drop) begin
        errors++;
        $display("FAIL burst_cyc %0d got trig=%b busy=%b sel=%0d pend=%b drops=%0d want %b %b %0d %b %0d",
                 c, trigger, busy, sel, pending, drop_count,
                 exp_trigger, exp_busy, exp_sel, exp_pending, exp_drop);
      end
      if (trigger === 1'b1) begin
        if (ntrig < 4) begin t_at[ntrig] = c; s_at[ntrig] = sel; end
        ntrig++;
      end
    end
    checks++;
    if (ntrig != 4) begin errors++; $display("FAIL burst_count got %0d want 4", ntrig); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (t_at[k] != k * SPACING || s_at[k] !== 2'(k)) begin
        errors++;
        $display("FAIL burst_grant %0d got cyc=%0d sel=%0d want cyc=%0d sel=%0d",
                 k, t_at[k], s_at[k], k * SPACING, k);
      end
    end
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL burst_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_fairness();
    int ntrig;
    logic [1:0] s_at[2];
    apply_reset();
    step(4'b0100, 1'b0);
    checks++;
    if (trigger !== 1'b1 || sel !== 2'd2) begin
      errors++; $display("FAIL fair_first got trig=%b sel=%0d want 1 2", trigger, sel);
    end
    repeat (3) step(4'd0, 1'b0);
    step(4'b0101, 1'b0);
    ntrig = 0;
    s_at[0] = 2'd3; s_at[1] = 2'd3;
    for (int c = 0; c < 3 * SPACING; c++) begin
      step(4'd0, 1'b0);
      if (trigger === 1'b1) begin
        if (ntrig < 2) s_at[ntrig] = sel;
        ntrig++;
      end
    end
    checks++;
    if (ntrig != 2 || s_at[0] !== 2'd0 || s_at[1] !== 2'd2) begin
      errors++;
      $display("FAIL fair_order got n=%0d sels=%0d,%0d want n=2 sels=0,2", ntrig, s_at[0], s_at[1]);
    end
  endtask

  task automatic test_drop_clear();
    apply_reset();
    step(4'b0001, 1'b0);
    repeat (3) step(4'd0, 1'b0);
    step(4'b0010, 1'b0);
    repeat (14) step(4'd0, 1'b0);
    step(4'b0010, 1'b0);
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_one got %0d want 1", drop_count); end
    step(4'b1100, 1'b0);
    step(4'b1100, 1'b0);
    checks++;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_three got %0d want 3", drop_count); end
    step(4'd0, 1'b1);
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_clear got %0d want 0", drop_count); end
    step(4'b0010, 1'b1);
    checks++;
    if (drop_count !== 16'd1) begin
      errors++; $display("FAIL drop_clear_same got %0d want 1", drop_count);
    end
    step(4'd0, 1'b1);
    checks++;
    if (drop_count !== 16'd0 || pending !== 4'b1110) begin
      errors++;
      $display("FAIL drop_end got drops=%0d pend=%b want 0 1110", drop_count, pending);
    end
  endtask

  task automatic test_saturate();
    int c;
    apply_reset();
    step(4'b0001, 1'b0);
    c = 0;
    while (m_raw_drops < 65537 && c < 40000) begin
      step(4'b1111, 1'b0);
      c++;
    end
    checks++;
    if (m_raw_drops < 65537) begin
      errors++; $display("FAIL sat_bound got %0d drops want >= 65537", m_raw_drops);
    end
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_value got %h want ffff", drop_count);
    end
    repeat (5) step(4'b1111, 1'b0);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h want ffff", drop_count);
    end
  endtask

  task automatic test_same_cycle();
    int c;
    apply_reset();
    step(4'b0001, 1'b0);
    step(4'd0, 1'b0);
    step(4'b0010, 1'b0);
    c = 0;
    while (m_left != 0 && c < 200) begin
      step(4'd0, 1'b0);
      c++;
    end
    step(4'b0010, 1'b0);
    checks++;
    if (trigger !== 1'b1 || sel !== 2'd1 || pending !== 4'b0010 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL same_grant got trig=%b sel=%0d pend=%b drops=%0d want 1 1 0010 0",
               trigger, sel, pending, drop_count);
    end
    c = 0;
    do begin
      step(4'd0, 1'b0);
      c++;
    end while (trigger !== 1'b1 && c < 200);
    checks++;
    if (c != SPACING || sel !== 2'd1 || pending !== 4'd0) begin
      errors++;
      $display("FAIL same_second got spacing=%0d sel=%0d pend=%b want %0d 1 0000",
               c, sel, pending, SPACING);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(4'b0001, 1'b0);
    step(4'b0110, 1'b0);
    repeat (5) step(4'd0, 1'b0);
    checks++;
    if (pending !== 4'b0110 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup got pend=%b busy=%b want 0110 1", pending, busy);
    end
    #3;
    n_reset = 1'b0;
    #2;
    checks++;
    if (trigger !== 1'b0 || sel !== 2'd0 || busy !== 1'b0 || pending !== 4'd0 ||
        drop_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_async got trig=%b sel=%0d busy=%b pend=%b drops=%0d want all 0",
               trigger, sel, busy, pending, drop_count);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    step(4'b1000, 1'b0);
    checks++;
    if (trigger !== 1'b1 || sel !== 2'd3 || pending !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got trig=%b sel=%0d pend=%b want 1 3 0000", trigger, sel, pending);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic c;
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) r = 4'(($urandom() % 15) + 1);
      c = ($urandom_range(0, 99) == 0);
      step(r, c);
      checks++;
      if (trigger !== exp_trigger || busy !== exp_busy || sel !== exp_sel ||
          pending !== exp_pending || drop_count !== exp_drop) begin
        errors++;
        $display("FAIL random_cyc %0d got trig=%b busy=%b sel=%0d pend=%b drops=%0d want %b %b %0d %b %0d",
                 n, trigger, busy, sel, pending, drop_count,
                 exp_trigger, exp_busy, exp_sel, exp_pending, exp_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fairness();
    test_drop_clear();
    test_saturate();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_scheduler.md
# trigger_scheduler

Shares one `pulse_gen` between `N_CH` independent delay channels. Each channel's `comparator` trigger becomes a request here. The block latches every request, grants the pulse generator round-robin, and enforces a busy/guard window so bursts never overlap. It sits between the per-channel comparators and a single `pulse_gen`, and drives the channel-select for the shared output path.

## Interface
Parameters:
- `N_CH`, 4: number of requesting delay channels (≥2).
- `BUSY_CYCLES`, 72: clock cycles one pulse_gen burst occupies, counted from the trigger cycle (≥1).
- `GUARD_CYCLES`, 8: idle cycles enforced after a burst (≥0).
- `DROP_WIDTH`, 16: width of the drop counter.

Ports:
- `clk`, in, 1: system clock.
- `n_reset`, in, 1: reset, asynchronous, active-low.
- `req`, in, N_CH: single-cycle trigger pulses, one bit per channel.
- `trigger`, out, 1: single-cycle start pulse to pulse_gen.
- `sel`, out, $clog2(N_CH): granted channel index, held stable until the next trigger.
- `busy`, out, 1: high from the trigger cycle until the end of guard.
- `pending`, out, N_CH: latched, unserved requests.
- `drop_count`, out, DROP_WIDTH: saturating count of lost requests.
- `drop_clear`, in, 1: synchronous clear of drop_count.

## Operation
- Per-channel pending flag:
  - Set when that channel's `req` bit is sampled high.
  - Cleared when the channel is granted.
- FSM states: IDLE, FIRE, BUSY, GUARD.
  - IDLE: candidates = `pending | req`. If any candidate is set, the round-robin pick is granted, `sel` loads its index, and the FSM goes to FIRE. If no candidate is set, the FSM stays in IDLE.
  - FIRE: lasts 1 cycle with `trigger`=1. Goes to BUSY, or to GUARD when BUSY_CYCLES=1.
  - BUSY: lasts BUSY_CYCLES-1 cycles, then goes to GUARD, or to IDLE when GUARD_CYCLES=0.
  - GUARD: lasts GUARD_CYCLES cycles, then goes to IDLE.
- Round-robin rule: search starts at (last granted + 1) mod N_CH. After reset, the search starts at channel 0.
- Grant from `req` directly: if a channel is granted straight from `req` in IDLE, its pending flag is never set.
- Drop: a request is dropped when a channel's `req` arrives while its pending flag is set and the channel is not being granted in that cycle.
  - `drop_count` adds the number of channels dropping in that cycle and saturates at all-ones.
- Drop clear: `drop_clear` has priority. `drop_count` loads the number of drops in the clear cycle, which is usually 0.
- Simultaneous request and grant: if a channel's `req` arrives in the same cycle its existing pending flag is granted, the new request sets pending again. This case is not a drop.
- Reset, including mid-burst: every output and internal register goes to 0 immediately. The FSM returns to IDLE and the round-robin pointer returns to 0. Pending requests are discarded and not counted as drops.

## Timing
- Reset values: `trigger`=0, `sel`=0, `busy`=0, `pending`=0, `drop_count`=0.
- Latency: `req` sampled at edge t with the FSM in IDLE gives `trigger` high for the cycle after edge t. This is a fixed 1 cycle (SCHED_LATENCY). The delay_line top subtracts it from its DELAY constant, alongside the existing sync/edge/output allowances.
- Under continuous load, the trigger-to-trigger spacing is exactly BUSY_CYCLES+GUARD_CYCLES+1 cycles.
- Worst-case wait for one request is N_CH×(BUSY_CYCLES+GUARD_CYCLES+1) cycles. Channels whose delay precision matters must keep their bursts spaced apart by more than this.
- `busy` is registered and equals the FSM state ≠ IDLE.
- `pending` is registered and reflects requests sampled up to the previous edge.
- `sel` changes only in the cycle `trigger` rises.

## Structure
- Shared package `delay_line_pkg` holds:
  - SCHED_LATENCY=1.
  - The FSM state encoding.
  - The function deriving BUSY_CYCLES from the modulation parameters: 2×clks-per-half-period×pulses.
- Sub-module `rr_pick`: purely combinational. Inputs are an N_CH request vector and a start index; outputs are a one-hot grant and a valid flag.
- `trigger_scheduler` itself holds the FSM, the cycle counter (width $clog2(max(BUSY_CYCLES,GUARD_CYCLES)+1)), the pending flags, the pointer and the drop counter.

## Test plan
- Single request: `req`=4'b0001 at edge 10 → `trigger` high in cycle 11 with `sel`=0; `busy` high cycles 11–90; next grant possible at edge 91 (defaults).
- Burst: `req`=4'b1111 in one cycle → triggers at cycles 11, 92, 173, 254 with `sel` = 0, 1, 2, 3; `pending` decrements bit-by-bit; `drop_count` stays 0.
- Fairness: after a grant to channel 2, `req`=4'b0101 arrives → next grant goes to channel 0 (search starts at 3); two grants to the same channel never occur while another is pending.
- Drop and clear:
  - Channel 1 requests at cycles 5 and 20 while busy serving channel 0 → `drop_count`=1.
  - Channels 2 and 3 double-request in one cycle → `drop_count`=3.
  - Assert `drop_clear` → `drop_count`=0.
  - Force 65537 drops → `drop_count`=16'hFFFF.
- Same-cycle re-request: channel 1's pending flag is granted while `req[1]` pulses in the same cycle → pending[1] set again, no drop, second trigger for `sel`=1 at spacing 81.
- Reset mid-burst: deassert `n_reset` in BUSY with pending=4'b0110 → all outputs 0 without waiting for a clock edge. After release, `req`=4'b1000 → `sel`=3 at latency 1.
